// File: rtl/clock_set_ctrl.sv
// Set/edit controller for a clock-calendar: button edge detection, edit-field FSM,
// blink prescaler and increment strobes. Define AUTO_EXIT_EN to add the idle auto-exit.
module clock_set_ctrl #(
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    output logic       mode,
    output logic [2:0] blink_mode,
    output logic       tick_blink,
    output logic       editing,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       inc_day,
    output logic       inc_month,
    output logic       inc_year,
    output logic       hold_time
);

    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("clock_set_ctrl: BLINK_DIV must be >= 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cyc
        $error("clock_set_ctrl: TIMEOUT_CYC must be >= 2");
    end

    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] E_SEC  = 3'd1;
    localparam logic [2:0] E_MIN  = 3'd2;
    localparam logic [2:0] E_HOUR = 3'd3;
    localparam logic [2:0] E_DAY  = 3'd4;
    localparam logic [2:0] E_MON  = 3'd5;
    localparam logic [2:0] E_YEAR = 3'd6;

    localparam int unsigned PRESC_W = $clog2(BLINK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_DIV - 1);

    logic [2:0]         state, state_d;
    logic               mode_d;
    logic               tick_d;
    logic [PRESC_W-1:0] presc, presc_d;
    logic [5:0]         inc_q, inc_d;

    // Button bits: [0] mode, [1] set, [2] inc
    logic [2:0] btn_q, btn_prev;
    logic [1:0] sample_ok;
    logic [2:0] press;
    logic       any_press;
    logic       timeout;

    // A press needs two post-reset samples, so a button held through reset never fires
    assign press     = btn_q & ~btn_prev & {3{sample_ok[1]}};
    assign any_press = |press;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q     <= '0;
            btn_prev  <= '0;
            sample_ok <= '0;
        end else begin
            btn_q     <= {btn_inc, btn_set, btn_mode};
            btn_prev  <= btn_q;
            sample_ok <= {sample_ok[0], 1'b1};
        end
    end

`ifdef AUTO_EXIT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_cnt, idle_d;

    assign timeout = editing && !any_press && (idle_cnt == IDLE_LAST);

    always_comb begin
        idle_d = idle_cnt + IDLE_W'(1);
        if (!editing || any_press || timeout) begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        mode_d  = mode;
        presc_d = presc;
        tick_d  = tick_blink;
        inc_d   = '0;
        case (state)
            RUN: begin
                presc_d = '0;
                tick_d  = 1'b0;
                if (press[1]) begin
                    state_d = mode ? E_SEC : E_DAY;
                end
                if (press[0]) begin
                    mode_d = ~mode;
                end
            end
            E_SEC, E_MIN, E_HOUR, E_DAY, E_MON, E_YEAR: begin
                if (timeout) begin
                    state_d = RUN;
                    presc_d = '0;
                    tick_d  = 1'b0;
                end else if (press[1]) begin
                    presc_d = '0;
                    tick_d  = 1'b0;
                    case (state)
                        E_SEC:   state_d = E_MIN;
                        E_MIN:   state_d = E_HOUR;
                        E_DAY:   state_d = E_MON;
                        E_MON:   state_d = E_YEAR;
                        default: state_d = RUN;
                    endcase
                end else if (press[2]) begin
                    presc_d = '0;
                    tick_d  = 1'b0;
                    case (state)
                        E_SEC:   inc_d[0] = 1'b1;
                        E_MIN:   inc_d[1] = 1'b1;
                        E_HOUR:  inc_d[2] = 1'b1;
                        E_DAY:   inc_d[3] = 1'b1;
                        E_MON:   inc_d[4] = 1'b1;
                        default: inc_d[5] = 1'b1;
                    endcase
                end else if (presc == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = ~tick_blink;
                end else begin
                    presc_d = presc + PRESC_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                presc_d = '0;
                tick_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            mode       <= 1'b1;
            presc      <= '0;
            tick_blink <= 1'b0;
            inc_q      <= '0;
        end else begin
            state      <= state_d;
            mode       <= mode_d;
            presc      <= presc_d;
            tick_blink <= tick_d;
            inc_q      <= inc_d;
        end
    end

    assign blink_mode = state;
    assign editing    = (state >= E_SEC) && (state <= E_YEAR);
    assign hold_time  = (state == E_SEC) || (state == E_MIN) || (state == E_HOUR);
    assign inc_sec    = inc_q[0];
    assign inc_min    = inc_q[1];
    assign inc_hour   = inc_q[2];
    assign inc_day    = inc_q[3];
    assign inc_month  = inc_q[4];
    assign inc_year   = inc_q[5];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed scenarios plus random button traffic,
// expected outputs come from a field/phase reference model; AUTO_EXIT_EN adds the timeout case.
module tb_clock_set_ctrl;

    localparam int unsigned BD = 4;
    localparam int unsigned TC = 20;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_set, btn_inc;
    logic       mode, tick_blink, editing, hold_time;
    logic [2:0] blink_mode;
    logic       inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year;

    always #5 clk = ~clk;

    clock_set_ctrl #(.BLINK_DIV(BD), .TIMEOUT_CYC(TC)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
        .mode(mode), .blink_mode(blink_mode), .tick_blink(tick_blink), .editing(editing),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour), .inc_day(inc_day),
        .inc_month(inc_month), .inc_year(inc_year), .hold_time(hold_time)
    );

    typedef struct {
        string      name;
        logic       mode;
        logic [2:0] bm;
        logic       tick;
        logic       editing;
        logic       hold;
        logic [5:0] inc;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    string phase = "reset";

    // Reference model: edited field (0 = none, 1..6 = sec..year), view, cycles since blink restart
    int         m_field;
    bit         m_mode;
    int         m_since;
    logic [2:0] m_hist[$];
`ifdef AUTO_EXIT_EN
    int         m_idle;
`endif

    task automatic model_edge(input logic r, input logic [2:0] smp);
        exp_t e;
        logic [5:0] inc;
        bit pm, ps, pi, to;
        inc = '0;
        if (r) begin
            m_field = 0;
            m_mode  = 1;
            m_since = 0;
            m_hist.delete();
`ifdef AUTO_EXIT_EN
            m_idle = 0;
`endif
        end else begin
            pm = 0; ps = 0; pi = 0; to = 0;
            if (m_hist.size() >= 2) begin
                logic [2:0] a, b;
                a  = m_hist[m_hist.size()-1];
                b  = m_hist[m_hist.size()-2];
                pm = a[0] && !b[0];
                ps = a[1] && !b[1];
                pi = a[2] && !b[2];
            end
            m_hist.push_back(smp);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
            if (m_field == 0) begin
                if (ps) m_field = m_mode ? 1 : 4;
                if (pm) m_mode = !m_mode;
                m_since = 0;
`ifdef AUTO_EXIT_EN
                m_idle = 0;
`endif
            end else begin
`ifdef AUTO_EXIT_EN
                to = !(pm || ps || pi) && (m_idle == TC - 1);
                m_idle = (pm || ps || pi || to) ? 0 : m_idle + 1;
`endif
                if (to) begin
                    m_field = 0;
                end else if (ps) begin
                    m_field = (m_field == 3 || m_field == 6) ? 0 : m_field + 1;
                    m_since = 0;
                end else if (pi) begin
                    inc[m_field-1] = 1'b1;
                    m_since = 0;
                end else begin
                    m_since++;
                end
                if (m_field == 0) m_since = 0;
            end
        end
        e.name    = phase;
        e.mode    = m_mode;
        e.bm      = 3'(m_field);
        e.tick    = (m_field != 0) && (((m_since / BD) % 2) == 1);
        e.editing = (m_field != 0);
        e.hold    = (m_field >= 1) && (m_field <= 3);
        e.inc     = inc;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic bm, input logic bs, input logic bi);
        rst = r; btn_mode = bm; btn_set = bs; btn_inc = bi;
        @(posedge clk);
        model_edge(r, {bi, bs, bm});
        #1;
    endtask

    task automatic pulse(input logic bm, input logic bs, input logic bi, input int gap);
        step(1'b0, bm, bs, bi);
        repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".mode"},       8'(mode),       8'(e.mode));
                chk({e.name, ".blink_mode"}, 8'(blink_mode), 8'(e.bm));
                chk({e.name, ".tick_blink"}, 8'(tick_blink), 8'(e.tick));
                chk({e.name, ".editing"},    8'(editing),    8'(e.editing));
                chk({e.name, ".hold_time"},  8'(hold_time),  8'(e.hold));
                chk({e.name, ".inc"},
                    8'({inc_year, inc_month, inc_day, inc_hour, inc_min, inc_sec}), 8'(e.inc));
            end
        end
    end

    initial begin
        // btn_set held through reset must not open an edit
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        phase = "held_thru_reset";
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

        phase = "entry_blink";
        pulse(1'b0, 1'b1, 1'b0, 14);

        phase = "time_path_min";
        pulse(1'b0, 1'b1, 1'b0, 3);
        phase = "inc_min_held";
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        phase = "time_path_hour";
        pulse(1'b0, 1'b1, 1'b0, 3);
        phase = "set_inc_same_cycle";
        pulse(1'b0, 1'b1, 1'b1, 4);
        phase = "run_inc_ignored";
        pulse(1'b0, 1'b0, 1'b1, 3);

        phase = "date_path";
        pulse(1'b1, 1'b0, 1'b0, 2);
        pulse(1'b0, 1'b1, 1'b0, 5);
        pulse(1'b1, 1'b0, 1'b0, 2);
        pulse(1'b0, 1'b0, 1'b1, 3);
        pulse(1'b0, 1'b1, 1'b0, 5);
        pulse(1'b0, 1'b1, 1'b0, 5);
        pulse(1'b0, 1'b0, 1'b1, 3);
        phase = "reset_mid_edit";
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef AUTO_EXIT_EN
        phase = "auto_exit";
        pulse(1'b1, 1'b0, 1'b0, 2);
        pulse(1'b0, 1'b1, 1'b0, 26);
        pulse(1'b0, 1'b1, 1'b0, 2);
        pulse(1'b0, 1'b1, 1'b0, 2);
        pulse(1'b0, 1'b1, 1'b0, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
`endif

        phase = "random";
        begin
            logic bm, bs, bi, r;
            bm = 0; bs = 0; bi = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 5) == 0) bm = ~bm;
                if ($urandom_range(0, 5) == 0) bs = ~bs;
                if ($urandom_range(0, 3) == 0) bi = ~bi;
                r = ($urandom_range(0, 299) == 0);
                step(r, bm, bs, bi);
            end
        end

        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
